dma_rd_engine: RTL and testbench

- Read half of the DMA datapath; sits directly downstream of the DMA register block.
- Consumes its start pulse, src_addr and size, and returns the done pulse it latches into reg0 bit 1.
- Splits a transfer into AXI4 INCR read bursts on an AXI4 master AR/R channel.
- Forwards every received beat on a valid/ready word stream to the write engine.

---
 rtl/dma_rd_engine_if.sv | 39 +++
 rtl/dma_rd_engine.sv | 128 ++++++++++++
 tb/tb_dma_rd_engine.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_rd_engine_if.sv
// AXI4 read-address/read-data channel plus the outgoing word stream of the DMA read engine.
interface dma_rd_engine_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              M_AXI_ARVALID;
    logic              M_AXI_ARREADY;
    logic [ADDR_W-1:0] M_AXI_ARADDR;
    logic [7:0]        M_AXI_ARLEN;
    logic [2:0]        M_AXI_ARSIZE;
    logic [1:0]        M_AXI_ARBURST;
    logic              M_AXI_RVALID;
    logic              M_AXI_RREADY;
    logic [DATA_W-1:0] M_AXI_RDATA;
    logic [1:0]        M_AXI_RRESP;
    logic              M_AXI_RLAST;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    modport master (
        output M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
        input  M_AXI_ARREADY,
        input  M_AXI_RVALID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST,
        output M_AXI_RREADY,
        output m_valid, m_data, m_last,
        input  m_ready
    );

    modport slave (
        input  M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
        output M_AXI_ARREADY,
        output M_AXI_RVALID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST,
        input  M_AXI_RREADY,
        input  m_valid, m_data, m_last,
        output m_ready
    );
endinterface

// File: rtl/dma_rd_engine.sv
// DMA read engine: splits a transfer into AXI4 INCR read bursts and streams the beats out.
// Define DMA_RD_4K_SPLIT_EN to keep every burst inside one 4KB page.
module dma_rd_engine #(
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [31:0]           src_addr,
    input  logic [15:0]           size,
    output logic                  done,
    output logic                  busy,
    output logic                  rd_err,
    dma_rd_engine_if.master       rd
);
    typedef enum logic [1:0] {StIdle, StAr, StData, StFin} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] araddr_q;
    logic [15:0]       remaining_q;
    logic [8:0]        beat_cnt_q;
    logic [7:0]        arlen_q;
    logic              arvalid_q;
    logic              done_q;
    logic              busy_q;
    logic              rd_err_q;
    logic [16:0]       beats;
    logic              in_data;
    logic              beat_fire;

`ifdef DMA_RD_4K_SPLIT_EN
    logic [16:0] page_room;
    assign page_room = 17'd1024 - 17'(addr_q[11:2]);
`endif

    always_comb begin
        beats = {1'b0, remaining_q};
        if (beats > 17'(MAX_BURST)) beats = 17'(MAX_BURST);
`ifdef DMA_RD_4K_SPLIT_EN
        if (beats > page_room) beats = page_room;
`endif
    end

    // The stream is a pure pass-through of the R channel while a burst is in flight.
    assign in_data          = (state_q == StData);
    assign beat_fire        = in_data & rd.M_AXI_RVALID & rd.m_ready;
    assign rd.M_AXI_RREADY  = in_data & rd.m_ready;
    assign rd.m_valid       = in_data & rd.M_AXI_RVALID;
    assign rd.m_data        = rd.M_AXI_RDATA;
    assign rd.m_last        = in_data & (remaining_q == 16'd1);

    assign rd.M_AXI_ARVALID = arvalid_q;
    assign rd.M_AXI_ARADDR  = araddr_q;
    assign rd.M_AXI_ARLEN   = arlen_q;
    assign rd.M_AXI_ARSIZE  = 3'b010;
    assign rd.M_AXI_ARBURST = 2'b01;

    assign done   = done_q;
    assign busy   = busy_q;
    assign rd_err = rd_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            araddr_q    <= '0;
            remaining_q <= '0;
            beat_cnt_q  <= '0;
            arlen_q     <= '0;
            arvalid_q   <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            rd_err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        rd_err_q <= 1'b0;
                        busy_q   <= 1'b1;
                        if (size != 16'd0) begin
                            addr_q      <= ADDR_W'(src_addr & 32'hFFFF_FFFC);
                            remaining_q <= size;
                            state_q     <= StAr;
                        end else begin
                            state_q <= StFin;
                        end
                    end
                end
                StAr: begin
                    // First cycle registers the request; it then holds until accepted.
                    if (!arvalid_q) begin
                        araddr_q  <= addr_q;
                        arlen_q   <= 8'(beats - 17'd1);
                        arvalid_q <= 1'b1;
                    end else if (rd.M_AXI_ARREADY) begin
                        arvalid_q  <= 1'b0;
                        beat_cnt_q <= 9'(arlen_q) + 9'd1;
                        state_q    <= StData;
                    end
                end
                StData: begin
                    if (beat_fire) begin
                        beat_cnt_q  <= beat_cnt_q - 9'd1;
                        remaining_q <= remaining_q - 16'd1;
                        addr_q      <= addr_q + ADDR_W'(4);
                        if ((rd.M_AXI_RRESP != 2'b00) ||
                            (rd.M_AXI_RLAST != (beat_cnt_q == 9'd1))) begin
                            rd_err_q <= 1'b1;
                        end
                        if (beat_cnt_q == 9'd1) begin
                            state_q <= (remaining_q == 16'd1) ? StFin : StAr;
                        end
                    end
                end
                StFin: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_dma_rd_engine.sv
// Scoreboard bench for dma_rd_engine: an AXI slave model answers bursts and every
// expected AR and stream word is queued at stimulus time and popped as the DUT produces it.
module tb_dma_rd_engine;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] src_addr;
    logic [15:0] size;
    logic        done;
    logic        busy;
    logic        rd_err;

    dma_rd_engine_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dma_rd_engine #(.MAX_BURST(16), .ADDR_W(32), .DATA_W(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .src_addr (src_addr),
        .size     (size),
        .done     (done),
        .busy     (busy),
        .rd_err   (rd_err),
        .rd       (bus)
    );

    typedef struct packed {logic [31:0] addr; logic [7:0] len;} ar_t;
    typedef struct packed {logic [31:0] data; logic last;} wd_t;

    ar_t exp_ar_q[$];
    ar_t slv_q[$];
    wd_t exp_w_q[$];

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned done_cnt = 0;
    int unsigned ar_wait  = 0;
    int unsigned ar_cnt   = 0;
    logic [31:0] err_addr = 32'h1;
    logic        r_fire   = 1'b0;
    logic        r_active = 1'b0;
    int          r_idx    = 0;
    int          r_len    = 0;
    logic [31:0] r_base   = '0;
    logic        ar_stalled = 1'b0;
    logic [31:0] prev_araddr = '0;
    logic [7:0]  prev_arlen  = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pat(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
    endfunction

    task automatic push_ar(input logic [31:0] a, input logic [7:0] l);
        exp_ar_q.push_back({a, l});
    endtask

    task automatic push_words(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_w_q.push_back({pat(base + 32'(4 * i)), 1'(i == n - 1)});
    endtask

    // Slave AR side: ARREADY held low for ar_wait cycles of each request.
    initial begin
        bus.M_AXI_ARREADY = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!bus.M_AXI_ARVALID) ar_cnt = 0;
            bus.M_AXI_ARREADY = (ar_cnt >= ar_wait);
            if (bus.M_AXI_ARVALID && !bus.M_AXI_ARREADY) ar_cnt++;
        end
    end

    // Slave R side: replays accepted bursts in order, data derived from the beat address.
    initial begin
        ar_t cur;
        bus.M_AXI_RVALID = 1'b0;
        bus.M_AXI_RDATA  = '0;
        bus.M_AXI_RRESP  = 2'b00;
        bus.M_AXI_RLAST  = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                r_active = 1'b0;
                slv_q.delete();
            end else begin
                if (r_active && r_fire) begin
                    if (r_idx == r_len) r_active = 1'b0;
                    else r_idx++;
                end
                if (!r_active && slv_q.size() > 0) begin
                    cur = slv_q.pop_front();
                    r_active = 1'b1;
                    r_idx = 0;
                    r_base = cur.addr;
                    r_len = int'(cur.len);
                end
            end
            bus.M_AXI_RVALID = r_active;
            bus.M_AXI_RDATA  = pat(r_base + 32'(4 * r_idx));
            bus.M_AXI_RLAST  = r_active && (r_idx == r_len);
            bus.M_AXI_RRESP  = (r_active && (r_base + 32'(4 * r_idx) == err_addr)) ? 2'b10 : 2'b00;
        end
    end

    // Monitor: a handshake seen here completes on the following rising edge.
    always @(negedge clk) begin
        ar_t e;
        wd_t w;
        if (!rst_n) begin
            r_fire = 1'b0;
            ar_stalled = 1'b0;
        end else begin
            r_fire = bus.M_AXI_RVALID & bus.M_AXI_RREADY;
            if (done) done_cnt++;
            check("rready_gate", bus.M_AXI_RREADY & ~bus.m_ready, 0);
            if (bus.m_valid) check("mdata_pass", bus.m_data, bus.M_AXI_RDATA);
            if (bus.M_AXI_ARVALID) check("ar_single_outstanding", r_active || slv_q.size() != 0, 0);
            if (ar_stalled) begin
                check("ar_hold_valid", bus.M_AXI_ARVALID, 1);
                check("ar_hold_addr", bus.M_AXI_ARADDR, prev_araddr);
                check("ar_hold_len", bus.M_AXI_ARLEN, prev_arlen);
            end
            ar_stalled  = bus.M_AXI_ARVALID & ~bus.M_AXI_ARREADY;
            prev_araddr = bus.M_AXI_ARADDR;
            prev_arlen  = bus.M_AXI_ARLEN;
            if (bus.M_AXI_ARVALID && bus.M_AXI_ARREADY) begin
                check("ar_expected", exp_ar_q.size() != 0, 1);
                if (exp_ar_q.size() != 0) begin
                    e = exp_ar_q.pop_front();
                    check("araddr", bus.M_AXI_ARADDR, e.addr);
                    check("arlen", bus.M_AXI_ARLEN, e.len);
                end
                check("arsize", bus.M_AXI_ARSIZE, 3'b010);
                check("arburst", bus.M_AXI_ARBURST, 2'b01);
                slv_q.push_back({bus.M_AXI_ARADDR, bus.M_AXI_ARLEN});
            end
            if (bus.m_valid && bus.m_ready) begin
                check("word_expected", exp_w_q.size() != 0, 1);
                if (exp_w_q.size() != 0) begin
                    w = exp_w_q.pop_front();
                    check("m_data", bus.m_data, w.data);
                    check("m_last", bus.m_last, w.last);
                end
            end
        end
    end

    // One transfer; optional ignored restarts at dup_a/dup_b and a 5-cycle m_ready gap at bp_from.
    task automatic run_xfer(input logic [31:0] addr, input logic [15:0] sz, input logic exp_err,
                            input int dup_a, input int dup_b, input int bp_from);
        bit seen = 0;
        int unsigned d0 = done_cnt;
        push_words(addr & 32'hFFFF_FFFC, int'(sz));
        for (int cyc = 0; cyc < 2000 && !seen; cyc++) begin
            @(posedge clk); #1;
            start    = (cyc == 0) || (cyc == dup_a) || (cyc == dup_b);
            src_addr = (cyc == 0) ? addr : 32'hDEAD_0100;
            size     = (cyc == 0) ? sz : 16'd7;
            bus.m_ready = !(bp_from > 0 && cyc >= bp_from && cyc < bp_from + 5);
            @(negedge clk);
            if (cyc == 1) begin
                check("busy_after_start", busy, 1);
                check("rd_err_cleared", rd_err, 0);
            end
            if (done) seen = 1;
        end
        start = 1'b0;
        bus.m_ready = 1'b1;
        check("done_seen", seen, 1);
        check("rd_err_end", rd_err, exp_err);
        check("busy_at_done", busy, 0);
        @(negedge clk);
        check("done_single", done, 0);
        check("done_count", done_cnt - d0, 1);
        check("ar_left", exp_ar_q.size(), 0);
        check("words_left", exp_w_q.size(), 0);
    endtask

    initial begin
        int unsigned d0;
        rst_n = 1'b0; start = 1'b0; src_addr = '0; size = '0; bus.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_rd_err", rd_err, 0);
        check("rst_arvalid", bus.M_AXI_ARVALID, 0);
        check("rst_rready", bus.M_AXI_RREADY, 0);
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_m_last", bus.m_last, 0);
        check("rst_araddr", bus.M_AXI_ARADDR, 0);
        check("rst_arlen", bus.M_AXI_ARLEN, 0);
        rst_n = 1'b1;

        push_ar(32'h1000, 8'd15); push_ar(32'h1040, 8'd15); push_ar(32'h1080, 8'd7);
        run_xfer(32'h1000, 16'd40, 1'b0, -1, -1, 0);

        // Zero-length transfer: one busy cycle, done two cycles after start.
        d0 = done_cnt;
        @(posedge clk); #1; start = 1'b1; src_addr = 32'h9000; size = 16'd0;
        @(negedge clk); check("z_busy_c0", busy, 0);
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk); check("z_busy_c1", busy, 1); check("z_done_c1", done, 0);
        @(negedge clk); check("z_busy_c2", busy, 0); check("z_done_c2", done, 1);
        check("z_arvalid", bus.M_AXI_ARVALID, 0);
        @(negedge clk); check("z_done_c3", done, 0);
        check("z_done_count", done_cnt - d0, 1);

        ar_wait = 3;
`ifdef DMA_RD_4K_SPLIT_EN
        push_ar(32'h0FF8, 8'd1); push_ar(32'h1000, 8'd5);
`else
        push_ar(32'h0FF8, 8'd7);
`endif
        run_xfer(32'h0FF8, 16'd8, 1'b0, -1, -1, 0);
        ar_wait = 0;

        push_ar(32'h2000, 8'd15); push_ar(32'h2040, 8'd3);
        run_xfer(32'h2000, 16'd20, 1'b0, 1, 8, 6);

        err_addr = 32'h3008;
        push_ar(32'h3000, 8'd3);
        run_xfer(32'h3000, 16'd4, 1'b1, -1, -1, 0);
        err_addr = 32'h1;
        push_ar(32'h3100, 8'd1);
        run_xfer(32'h3102, 16'd2, 1'b0, -1, -1, 0);

        ar_wait = 2;
        push_ar(32'h6000, 8'd15); push_ar(32'h6040, 8'd0);
        run_xfer(32'h6000, 16'd17, 1'b0, -1, -1, 0);
        ar_wait = 0;

`ifdef DMA_RD_4K_SPLIT_EN
        push_ar(32'hFFFF_FFF8, 8'd1); push_ar(32'h0000_0000, 8'd1);
`else
        push_ar(32'hFFFF_FFF8, 8'd3);
`endif
        run_xfer(32'hFFFF_FFF8, 16'd4, 1'b0, -1, -1, 0);

        // Reset in the middle of a burst.
        push_ar(32'h4000, 8'd15);
        push_words(32'h4000, 16);
        @(posedge clk); #1; start = 1'b1; src_addr = 32'h4000; size = 16'd32;
        @(posedge clk); #1; start = 1'b0;
        for (int i = 0; i < 200 && exp_w_q.size() > 12; i++) @(negedge clk);
        check("mid_data_reached", exp_w_q.size() <= 12, 1);
        check("mid_rready", bus.M_AXI_RREADY, 1);
        check("mid_busy", busy, 1);
        #2; rst_n = 1'b0;
        #1;
        check("arst_arvalid", bus.M_AXI_ARVALID, 0);
        check("arst_rready", bus.M_AXI_RREADY, 0);
        check("arst_busy", busy, 0);
        check("arst_m_valid", bus.m_valid, 0);
        exp_ar_q.delete();
        exp_w_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("arst_araddr", bus.M_AXI_ARADDR, 0);
        rst_n = 1'b1;

        push_ar(32'h7000, 8'd2);
        run_xfer(32'h7000, 16'd3, 1'b0, -1, -1, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
